// File: rtl/io_serdes_pkg.sv
// Shared types and helpers for the byte-serial adder host.
// Holds the host FSM states, the adder-select encodings and the byte-count helper.
package io_serdes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        START,
        WAIT,
        READ,
        DONE
    } host_state_t;

    localparam logic [1:0] SEL_RCA = 2'b10;
    localparam logic [1:0] SEL_CLA = 2'b11;

    function automatic int nbytes(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/io_serdes_host.sv
// Host-side initiator for the byte-serial adder: streams A then B low byte first,
// strobes the calculation, reads the sum back byte by byte and returns it with the carry-out.
module io_serdes_host
    import io_serdes_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CALC_WAIT = 1,
    parameter int READ_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_rca,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_z,
    output logic             res_ovf,
    output logic [7:0]       dut_in,
    output logic [1:0]       dut_sel,
    output logic             dut_start,
    output logic             dut_output,
    input  logic [7:0]       dut_out,
    input  logic             dut_ovf_cla,
    input  logic             dut_ovf_rca
);

    localparam int NB   = nbytes(WIDTH);
    localparam int CNTW = $clog2(NB + READ_LAT + CALC_WAIT) + 1;

    localparam logic [CNTW-1:0] NB_C     = CNTW'(NB);
    localparam logic [CNTW-1:0] SEND_END = CNTW'(NB - 1);
    localparam logic [CNTW-1:0] WAIT_END = CNTW'(CALC_WAIT - 1);
    localparam logic [CNTW-1:0] READ_END = CNTW'(NB + READ_LAT - 1);

    host_state_t      state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             rca_q, rca_d;
    logic [1:0]       sel_q, sel_d;
    logic [WIDTH-1:0] res_z_q, res_z_d;
    logic             res_ovf_q, res_ovf_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       dut_in_q, dut_in_d;
    logic             dut_start_q, dut_start_d;
    logic             dut_output_q, dut_output_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rca_q        <= 1'b0;
            sel_q        <= SEL_CLA;
            res_z_q      <= '0;
            res_ovf_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            dut_in_q     <= '0;
            dut_start_q  <= 1'b0;
            dut_output_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            rca_q        <= rca_d;
            sel_q        <= sel_d;
            res_z_q      <= res_z_d;
            res_ovf_q    <= res_ovf_d;
            res_valid_q  <= res_valid_d;
            dut_in_q     <= dut_in_d;
            dut_start_q  <= dut_start_d;
            dut_output_q <= dut_output_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        rca_d     = rca_q;
        sel_d     = sel_q;
        res_z_d   = res_z_q;
        res_ovf_d = res_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    rca_d   = op_rca;
                    sel_d   = op_rca ? SEL_RCA : SEL_CLA;
                    state_d = SEND_A;
                    cnt_d   = '0;
                end
            end
            SEND_A: begin
                if (cnt_q == SEND_END) begin
                    state_d = SEND_B;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SEND_B: begin
                if (cnt_q == SEND_END) begin
                    state_d = START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            START: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                if (cnt_q == WAIT_END) begin
                    state_d = READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READ: begin
                // Bytes arrive READ_LAT cycles behind each request, so capture lags the counter.
                if (cnt_q == '0) begin
                    res_ovf_d = rca_q ? dut_ovf_rca : dut_ovf_cla;
                end
                if (int'(cnt_q) >= READ_LAT) begin
                    res_z_d[8*(int'(cnt_q) - READ_LAT) +: 8] = dut_out;
                end
                if (cnt_q == READ_END) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Bus outputs are registered, so they are decoded from the next state.
        res_valid_d  = (state_d == DONE);
        dut_start_d  = (state_d == START);
        dut_output_d = (state_d == READ) && (cnt_d < NB_C);
        dut_in_d     = '0;
        if (state_d == SEND_A) begin
            dut_in_d = a_d[8*int'(cnt_d) +: 8];
        end else if (state_d == SEND_B) begin
            dut_in_d = b_d[8*int'(cnt_d) +: 8];
        end
    end

    assign op_ready   = (state_q == IDLE) && !rst;
    assign res_valid  = res_valid_q;
    assign res_z      = res_z_q;
    assign res_ovf    = res_ovf_q;
    assign dut_in     = dut_in_q;
    assign dut_sel    = sel_q;
    assign dut_start  = dut_start_q;
    assign dut_output = dut_output_q;

endmodule
